control_sequencer: RTL and testbench

- Moore-style control unit that sits directly upstream of the datapath and drives its per-cycle control strobes.
- Executes fetch (T0–T2), then decodes IR[31:27] and runs T3–T6 for register ALU, shift/rotate, mul/div, neg/not, nop and halt instructions.
- Register selection uses Gra/Grb/Grc plus Rin/Rout. A downstream select-and-encode block turns these into R0in..R15in and R0out..R15out.

---
 rtl/cpu_ctrl_pkg.sv | 69 ++++++
 rtl/control_sequencer_if.sv | 51 +++++
 rtl/opcode_class_decode.sv | 35 +++
 rtl/control_sequencer.sv | 127 ++++++++++++
 tb/tb_control_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module : cpu_ctrl_pkg
// Desc   : Shared encodings for control_sequencer: state codes, opcodes,
//          instruction field positions, and opcode classes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  localparam int c_OPW   = 5;
  localparam int c_IRW   = 32;
  localparam int c_REG_W = 4;

  // Instruction layout: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
  localparam int c_IR_RC_LSB  = 15;
  localparam int c_IR_RB_LSB  = c_IR_RC_LSB + c_REG_W;
  localparam int c_IR_RA_LSB  = c_IR_RB_LSB + c_REG_W;
  localparam int c_IR_OPC_LSB = c_IR_RA_LSB + c_REG_W;

  localparam logic [3:0] c_ST_RST  = 4'd0;
  localparam logic [3:0] c_ST_T0   = 4'd1;
  localparam logic [3:0] c_ST_T1   = 4'd2;
  localparam logic [3:0] c_ST_T2   = 4'd3;
  localparam logic [3:0] c_ST_T3   = 4'd4;
  localparam logic [3:0] c_ST_T4   = 4'd5;
  localparam logic [3:0] c_ST_T5   = 4'd6;
  localparam logic [3:0] c_ST_T6   = 4'd7;
  localparam logic [3:0] c_ST_HALT = 4'd8;

  typedef enum logic [3:0] {
    ST_RST  = c_ST_RST,
    ST_T0   = c_ST_T0,
    ST_T1   = c_ST_T1,
    ST_T2   = c_ST_T2,
    ST_T3   = c_ST_T3,
    ST_T4   = c_ST_T4,
    ST_T5   = c_ST_T5,
    ST_T6   = c_ST_T6,
    ST_HALT = c_ST_HALT
  } state_t;

  localparam logic [c_OPW-1:0] c_OPC_ADD  = 5'b00000;
  localparam logic [c_OPW-1:0] c_OPC_SUB  = 5'b00001;
  localparam logic [c_OPW-1:0] c_OPC_AND  = 5'b00010;
  localparam logic [c_OPW-1:0] c_OPC_OR   = 5'b00011;
  localparam logic [c_OPW-1:0] c_OPC_SHR  = 5'b00100;
  localparam logic [c_OPW-1:0] c_OPC_SHRA = 5'b00101;
  localparam logic [c_OPW-1:0] c_OPC_SHL  = 5'b00110;
  localparam logic [c_OPW-1:0] c_OPC_ROR  = 5'b00111;
  localparam logic [c_OPW-1:0] c_OPC_ROL  = 5'b01000;
  localparam logic [c_OPW-1:0] c_OPC_MUL  = 5'b01001;
  localparam logic [c_OPW-1:0] c_OPC_DIV  = 5'b01010;
  localparam logic [c_OPW-1:0] c_OPC_NEG  = 5'b01011;
  localparam logic [c_OPW-1:0] c_OPC_NOT  = 5'b01100;
  localparam logic [c_OPW-1:0] c_OPC_NOP  = 5'b11010;
  localparam logic [c_OPW-1:0] c_OPC_HALT = 5'b11011;

  typedef enum logic [2:0] {
    CLS_ALU2   = 3'd0,
    CLS_MULDIV = 3'd1,
    CLS_UNARY  = 3'd2,
    CLS_NOP    = 3'd3,
    CLS_HALT   = 3'd4
  } op_class_t;

endpackage

`default_nettype wire

// File: rtl/control_sequencer_if.sv
// ============================================================================
// Module : control_sequencer_if
// Desc   : Instruction/strobe bundle between control_sequencer and datapath.
//          Mem_ready exists only when CS_MEM_WAIT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface control_sequencer_if
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = c_OPW,
  parameter int IRW = c_IRW
);

  logic [IRW-1:0] IR;
  logic           Stop;
`ifdef CS_MEM_WAIT_EN
  logic           Mem_ready;
`endif
  logic           Run;
  logic           PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
  logic           Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin;
  logic           Gra, Grb, Grc, Rin, Rout;
  logic [OPW-1:0] OP;

  modport master (
`ifdef CS_MEM_WAIT_EN
    input  Mem_ready,
`endif
    input  IR, Stop,
    output Run,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
    output Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin,
    output Gra, Grb, Grc, Rin, Rout, OP
  );

  modport slave (
`ifdef CS_MEM_WAIT_EN
    output Mem_ready,
`endif
    output IR, Stop,
    input  Run,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
    input  Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin,
    input  Gra, Grb, Grc, Rin, Rout, OP
  );

endinterface

`default_nettype wire

// File: rtl/opcode_class_decode.sv
// ============================================================================
// Module : opcode_class_decode
// Desc   : Maps an instruction opcode onto its execution class.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module opcode_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [c_OPW-1:0] i_opcode,
  output op_class_t        o_class
);

  always_comb begin
    o_class = CLS_NOP;
    case (i_opcode)
      c_OPC_ADD, c_OPC_SUB, c_OPC_AND, c_OPC_OR,
      c_OPC_SHR, c_OPC_SHRA, c_OPC_SHL, c_OPC_ROR, c_OPC_ROL:
        o_class = CLS_ALU2;
      c_OPC_MUL, c_OPC_DIV:
        o_class = CLS_MULDIV;
      c_OPC_NEG, c_OPC_NOT:
        o_class = CLS_UNARY;
      c_OPC_HALT:
        o_class = CLS_HALT;
      // Undefined opcodes fall through to NOP
      default:
        o_class = CLS_NOP;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module : control_sequencer
// Desc   : Moore control unit: fetch T0-T2, execute T3-T6, HALT. Outputs are
//          decoded from state and IR. CS_MEM_WAIT_EN stretches T1 on Mem_ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                Clock,
  input  logic                Clear,
  control_sequencer_if.master bus
);

  state_t           r_state;
  op_class_t        w_class;
  logic [c_OPW-1:0] w_opcode;

  assign w_opcode = bus.IR[c_IR_OPC_LSB +: c_OPW];

  opcode_class_decode u_class_dec (
    .i_opcode (w_opcode),
    .o_class  (w_class)
  );

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state <= ST_RST;
    end else begin
      case (r_state)
        ST_RST:  r_state <= ST_T0;
        ST_T0:   r_state <= bus.Stop ? ST_HALT : ST_T1;
`ifdef CS_MEM_WAIT_EN
        ST_T1:   r_state <= bus.Mem_ready ? ST_T2 : ST_T1;
`else
        ST_T1:   r_state <= ST_T2;
`endif
        ST_T2:   r_state <= ST_T3;
        ST_T3: begin
          case (w_class)
            CLS_NOP:  r_state <= ST_T0;
            CLS_HALT: r_state <= ST_HALT;
            default:  r_state <= ST_T4;
          endcase
        end
        ST_T4:   r_state <= (w_class == CLS_UNARY)  ? ST_T0 : ST_T5;
        ST_T5:   r_state <= (w_class == CLS_MULDIV) ? ST_T6 : ST_T0;
        ST_T6:   r_state <= ST_T0;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RST;
      endcase
    end
  end

  always_comb begin
    bus.Run      = 1'b0;
    bus.PCout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.Read     = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.ZLowin   = 1'b0;
    bus.ZHighin  = 1'b0;
    bus.ZLowout  = 1'b0;
    bus.ZHighout = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.OP       = '0;
    case (r_state)
      ST_T0: begin
        bus.Run = 1'b1; bus.PCout = 1'b1; bus.MARin = 1'b1;
        bus.IncPC = 1'b1; bus.ZLowin = 1'b1;
      end
      ST_T1: begin
        bus.Run = 1'b1; bus.ZLowout = 1'b1; bus.PCin = 1'b1;
        bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      ST_T2: begin
        bus.Run = 1'b1; bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      ST_T3: begin
        bus.Run = 1'b1;
        if (w_class == CLS_ALU2 || w_class == CLS_MULDIV) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (w_class == CLS_UNARY) begin
          // Unary ops feed the ALU straight from Rb, no Y staging
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.OP = w_opcode; bus.ZLowin = 1'b1;
        end
      end
      ST_T4: begin
        bus.Run = 1'b1;
        if (w_class == CLS_UNARY) begin
          bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.OP = w_opcode; bus.ZLowin = 1'b1;
          bus.ZHighin = (w_class == CLS_MULDIV);
        end
      end
      ST_T5: begin
        bus.Run = 1'b1; bus.ZLowout = 1'b1;
        if (w_class == CLS_MULDIV) begin
          bus.LOin = 1'b1;
        end else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      ST_T6: begin
        bus.Run = 1'b1; bus.ZHighout = 1'b1; bus.HIin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module : tb_control_sequencer
// Desc   : Scoreboard bench for control_sequencer; define CS_MEM_WAIT_EN to
//          also exercise the T1 memory wait.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  localparam logic [25:0] B_RUN      = 26'd1 << 25;
  localparam logic [25:0] B_PCOUT    = 26'd1 << 24;
  localparam logic [25:0] B_PCIN     = 26'd1 << 23;
  localparam logic [25:0] B_INCPC    = 26'd1 << 22;
  localparam logic [25:0] B_MARIN    = 26'd1 << 21;
  localparam logic [25:0] B_MDRIN    = 26'd1 << 20;
  localparam logic [25:0] B_MDROUT   = 26'd1 << 19;
  localparam logic [25:0] B_READ     = 26'd1 << 18;
  localparam logic [25:0] B_IRIN     = 26'd1 << 17;
  localparam logic [25:0] B_YIN      = 26'd1 << 16;
  localparam logic [25:0] B_ZLOWIN   = 26'd1 << 15;
  localparam logic [25:0] B_ZHIGHIN  = 26'd1 << 14;
  localparam logic [25:0] B_ZLOWOUT  = 26'd1 << 13;
  localparam logic [25:0] B_ZHIGHOUT = 26'd1 << 12;
  localparam logic [25:0] B_HIIN     = 26'd1 << 11;
  localparam logic [25:0] B_LOIN     = 26'd1 << 10;
  localparam logic [25:0] B_GRA      = 26'd1 << 9;
  localparam logic [25:0] B_GRB      = 26'd1 << 8;
  localparam logic [25:0] B_GRC      = 26'd1 << 7;
  localparam logic [25:0] B_RIN      = 26'd1 << 6;
  localparam logic [25:0] B_ROUT     = 26'd1 << 5;

  localparam logic [25:0] E_IDLE = 26'd0;
  localparam logic [25:0] E_T0   = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
  localparam logic [25:0] E_T1   = B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [25:0] E_T2   = B_RUN | B_MDROUT | B_IRIN;
  localparam logic [25:0] E_RB_Y = B_RUN | B_GRB | B_ROUT | B_YIN;
  localparam logic [25:0] E_WB_A = B_RUN | B_ZLOWOUT | B_GRA | B_RIN;

  logic Clock = 1'b0;
  logic Clear;
  always #5 Clock = ~Clock;

  control_sequencer_if bus ();

  control_sequencer dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  logic [25:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;

  // Monitor: one expected vector per cycle, compared mid-cycle
  always @(negedge Clock) begin : mon
    logic [25:0] act;
    logic [25:0] e;
    string       n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      act = {bus.Run, bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin,
             bus.MDRout, bus.Read, bus.IRin, bus.Yin, bus.ZLowin, bus.ZHighin,
             bus.ZLowout, bus.ZHighout, bus.HIin, bus.LOin, bus.Gra, bus.Grb,
             bus.Grc, bus.Rin, bus.Rout, bus.OP};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %07h want %07h", n, act, e);
      end
      total++;
      if ((bus.Rin & bus.Rout) !== 1'b0) begin
        bad++;
        $display("FAIL %s rin_rout: got %b want 0", n, bus.Rin & bus.Rout);
      end
      total++;
      if ($countones({bus.Gra, bus.Grb, bus.Grc}) > 1) begin
        bad++;
        $display("FAIL %s gr_onehot: got %b%b%b want at most one", n,
                 bus.Gra, bus.Grb, bus.Grc);
      end
    end
  end

  task automatic cyc(input logic [25:0] e, input string n);
    @(posedge Clock);
    #1;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic fetch(input logic [31:0] ir);
    cyc(E_T0, "t0");
    bus.IR = ir;
    cyc(E_T1, "t1");
    cyc(E_T2, "t2");
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Clear    = 1'b1;
    bus.IR   = 32'h0;
    bus.Stop = 1'b0;
`ifdef CS_MEM_WAIT_EN
    bus.Mem_ready = 1'b1;
`endif
    cyc(E_IDLE, "rst_0");
    cyc(E_IDLE, "rst_1");
    Clear = 1'b0;

    // SHRA R1,R3
    fetch(32'h2898_0000);
    cyc(E_RB_Y, "shra_t3");
    cyc(B_RUN | B_GRC | B_ROUT | B_ZLOWIN | 26'd5, "shra_t4");
    cyc(E_WB_A, "shra_t5");

    // ROL: last two-operand opcode
    fetch(32'h4000_0000);
    cyc(E_RB_Y, "rol_t3");
    cyc(B_RUN | B_GRC | B_ROUT | B_ZLOWIN | 26'd8, "rol_t4");
    cyc(E_WB_A, "rol_t5");

    // MUL
    fetch(32'h4800_0000);
    cyc(E_RB_Y, "mul_t3");
    cyc(B_RUN | B_GRC | B_ROUT | B_ZLOWIN | B_ZHIGHIN | 26'd9, "mul_t4");
    cyc(B_RUN | B_ZLOWOUT | B_LOIN, "mul_t5");
    cyc(B_RUN | B_ZHIGHOUT | B_HIIN, "mul_t6");

    // NOT
    fetch(32'h6000_0000);
    cyc(B_RUN | B_GRB | B_ROUT | B_ZLOWIN | 26'd12, "not_t3");
    cyc(E_WB_A, "not_t4");

    // NOP, then an undefined opcode behaving as NOP
    fetch(32'hD000_0000);
    cyc(B_RUN, "nop_t3");
    fetch(32'hF800_0000);
    cyc(B_RUN, "undef_t3");

    // DIV interrupted by Clear in T4
    fetch(32'h5000_0000);
    cyc(E_RB_Y, "div_t3");
    cyc(B_RUN | B_GRC | B_ROUT | B_ZLOWIN | B_ZHIGHIN | 26'd10, "div_t4");
    Clear = 1'b1;
    cyc(E_IDLE, "clr_in_t4");
    Clear = 1'b0;

    // Stop sampled in T0
    cyc(E_T0, "t0_after_clr");
    bus.Stop = 1'b1;
    cyc(E_IDLE, "stop_halt");
    total++;
    if (bus.Run !== 1'b0) begin
        bad++;
        $display("FAIL stop_halt_run: got %b want 0", bus.Run);
    end
    total++;
    if (bus.OP !== 5'd0) begin
        bad++;
        $display("FAIL stop_halt_op: got %05b want 00000", bus.OP);
    end
    bus.Stop = 1'b0;
    repeat (3) cyc(E_IDLE, "stop_halt_hold");
    Clear = 1'b1;
    cyc(E_IDLE, "halt_clr");
    Clear = 1'b0;

    // HALT opcode
    fetch(32'hD800_0000);
    cyc(B_RUN, "haltop_t3");
    repeat (10) cyc(E_IDLE, "haltop_hold");
    Clear = 1'b1;
    cyc(E_IDLE, "haltop_clr");
    Clear = 1'b0;

`ifdef CS_MEM_WAIT_EN
    bus.IR = 32'hD000_0000;
    cyc(E_T0, "mw_t0");
    bus.Mem_ready = 1'b0;
    repeat (4) cyc(E_T1, "mw_t1_hold");
    bus.Mem_ready = 1'b1;
    cyc(E_T2, "mw_t2");
    cyc(B_RUN, "mw_nop_t3");
    cyc(E_T0, "mw2_t0");
    bus.Mem_ready = 1'b0;
    cyc(E_T1, "mw2_t1");
    cyc(E_T1, "mw2_t1_hold");
    Clear = 1'b1;
    cyc(E_IDLE, "mw2_clr");
    Clear = 1'b0;
    bus.Mem_ready = 1'b1;
`endif

    cyc(E_T0, "final_t0");
    @(negedge Clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0)
        $display("PASS");
    else
        $display("FAIL summary: got %0d mismatches want 0", bad);
    $finish;
  end

endmodule

`default_nettype wire
